mem_arbiter: RTL and testbench

- Shares one backing-memory port between the instruction cache and the data cache.
- Each cache drives the split write/read request-ack protocol used by cache_2way-style blocks; the arbiter selects one client and forwards its transaction downstream.
- It returns the ack, and read data for reads, to the selected client only.
- Sits between the two L1 caches and the memory model or bus.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants for the two-client backing-memory arbiter:
//   line width, FSM state encodings, grant encodings, client bit
//   positions in the request/winner vectors, and the arbitration mode.
//
//   Build option: define MEM_ARB_ROUND_ROBIN_EN to make the IDLE picker
//   alternate between the two caches under contention. Left undefined,
//   the dcache always wins.
package mem_arbiter_pkg;

  localparam int MEMORY_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arb_gnt_e;

  // Bit positions of each client in the request / winner vectors.
  localparam int CLI_I = 0;
  localparam int CLI_D = 1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_ENABLE = 1'b1;
`else
  localparam bit RR_ENABLE = 1'b0;
`endif

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational two-way picker for the memory arbiter.
//
//   Ports:
//     req_i      [1:0]  per-client request (bit CLI_I icache, bit CLI_D dcache)
//     rr_last_i         client served at the last DONE (1 = dcache)
//     win_o      [1:0]  one-hot winner, all zero when nobody requests
//
//   Parameter ROUND_ROBIN selects alternation under contention; when 0
//   the dcache wins every tie and rr_last_i has no effect.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = req_i;
    if (req_i == 2'b11) begin
      win_o = 2'b00;
      // On a tie, the client that was not served last gets the port.
      if (ROUND_ROBIN && rr_last_i) begin
        win_o[CLI_I] = 1'b1;
      end else begin
        win_o[CLI_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one backing-memory port between the icache (i_*) and the
//   dcache (d_*). Each client uses a split write/read level request with
//   a one-cycle ack pulse; the arbiter forwards the granted client's
//   transaction downstream (mem_*) and returns ack and read data to that
//   client only. A client asking for write and read together gets the
//   write first and the read chained straight after it (evict+fill),
//   with no chance for the other client to slip in between.
//
//   Ports:
//     clk, reset            clock; synchronous active-low reset
//     i_write_*/i_read_*    icache request/ack/data
//     d_write_*/d_read_*    dcache request/ack/data
//     mem_write_*/mem_read_* downstream request/ack/data
//
//   Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arbiter_pkg).
//
//   state | meaning
//   IDLE  | no grant; pick a winner among requesting clients
//   WRITE | mem_write_req high, waiting for mem_write_ack
//   READ  | mem_read_req high, waiting for mem_read_ack
//   DONE  | turnaround; ack pulse to the granted client
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = MEMORY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_write_req,
  input  logic [31:0]      i_write_addr,
  input  logic [WIDTH-1:0] i_write_data,
  output logic             i_write_ack,
  input  logic             i_read_req,
  input  logic [31:0]      i_read_addr,
  output logic [WIDTH-1:0] i_read_data,
  output logic             i_read_ack,

  input  logic             d_write_req,
  input  logic [31:0]      d_write_addr,
  input  logic [WIDTH-1:0] d_write_data,
  output logic             d_write_ack,
  input  logic             d_read_req,
  input  logic [31:0]      d_read_addr,
  output logic [WIDTH-1:0] d_read_data,
  output logic             d_read_ack,

  output logic             mem_write_req,
  output logic [31:0]      mem_write_addr,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic             mem_write_ack,
  output logic             mem_read_req,
  output logic [31:0]      mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_read_ack
);

  arb_state_e       state_q;
  arb_gnt_e         grant_q;
  logic             rr_last_q;
  logic             was_write_q;

  logic             mem_write_req_q;
  logic [31:0]      mem_write_addr_q;
  logic [WIDTH-1:0] mem_write_data_q;
  logic             mem_read_req_q;
  logic [31:0]      mem_read_addr_q;

  logic             i_write_ack_q;
  logic             i_read_ack_q;
  logic             d_write_ack_q;
  logic             d_read_ack_q;
  logic [WIDTH-1:0] i_read_data_q;
  logic [WIDTH-1:0] d_read_data_q;

  logic [1:0]       cli_req;
  logic [1:0]       win;

  assign cli_req[CLI_I] = i_write_req | i_read_req;
  assign cli_req[CLI_D] = d_write_req | d_read_req;

  mem_arb_pick #(
    .ROUND_ROBIN (RR_ENABLE)
  ) u_pick (
    .req_i     (cli_req),
    .rr_last_i (rr_last_q),
    .win_o     (win)
  );

  // Request fields of the IDLE winner.
  logic             sel_d;
  logic             sel_wr_req;
  logic [31:0]      sel_wr_addr;
  logic [WIDTH-1:0] sel_wr_data;
  logic [31:0]      sel_rd_addr;

  assign sel_d       = win[CLI_D];
  assign sel_wr_req  = sel_d ? d_write_req  : i_write_req;
  assign sel_wr_addr = sel_d ? d_write_addr : i_write_addr;
  assign sel_wr_data = sel_d ? d_write_data : i_write_data;
  assign sel_rd_addr = sel_d ? d_read_addr  : i_read_addr;

  // Read request of the client currently holding the grant, used to
  // chain the fill after its eviction.
  logic             gnt_d;
  logic             gnt_rd_req;
  logic [31:0]      gnt_rd_addr;

  assign gnt_d       = (grant_q == GNT_D);
  assign gnt_rd_req  = gnt_d ? d_read_req  : i_read_req;
  assign gnt_rd_addr = gnt_d ? d_read_addr : i_read_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ARB_IDLE;
      grant_q          <= GNT_NONE;
      rr_last_q        <= 1'b0;
      was_write_q      <= 1'b0;
      mem_write_req_q  <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      mem_read_req_q   <= 1'b0;
      mem_read_addr_q  <= '0;
      i_write_ack_q    <= 1'b0;
      i_read_ack_q     <= 1'b0;
      d_write_ack_q    <= 1'b0;
      d_read_ack_q     <= 1'b0;
      i_read_data_q    <= '0;
      d_read_data_q    <= '0;
    end else begin
      // Client acks live for the DONE cycle only.
      i_write_ack_q <= 1'b0;
      i_read_ack_q  <= 1'b0;
      d_write_ack_q <= 1'b0;
      d_read_ack_q  <= 1'b0;

      case (state_q)
        ARB_IDLE: begin
          if (win != 2'b00) begin
            grant_q <= sel_d ? GNT_D : GNT_I;
            // A pending write always goes before the same client's read.
            if (sel_wr_req) begin
              mem_write_req_q  <= 1'b1;
              mem_write_addr_q <= sel_wr_addr;
              mem_write_data_q <= sel_wr_data;
              was_write_q      <= 1'b1;
              state_q          <= ARB_WRITE;
            end else begin
              mem_read_req_q   <= 1'b1;
              mem_read_addr_q  <= sel_rd_addr;
              was_write_q      <= 1'b0;
              state_q          <= ARB_READ;
            end
          end
        end

        ARB_WRITE: begin
          if (mem_write_ack) begin
            mem_write_req_q <= 1'b0;
            state_q         <= ARB_DONE;
            if (gnt_d) begin
              d_write_ack_q <= 1'b1;
            end else begin
              i_write_ack_q <= 1'b1;
            end
          end
        end

        ARB_READ: begin
          if (mem_read_ack) begin
            mem_read_req_q <= 1'b0;
            state_q        <= ARB_DONE;
            if (gnt_d) begin
              d_read_data_q <= mem_read_data;
              d_read_ack_q  <= 1'b1;
            end else begin
              i_read_data_q <= mem_read_data;
              i_read_ack_q  <= 1'b1;
            end
          end
        end

        ARB_DONE: begin
          rr_last_q <= gnt_d;
          // Fill straight after the eviction, keeping the grant.
          if (was_write_q && gnt_rd_req) begin
            mem_read_req_q  <= 1'b1;
            mem_read_addr_q <= gnt_rd_addr;
            was_write_q     <= 1'b0;
            state_q         <= ARB_READ;
          end else begin
            grant_q <= GNT_NONE;
            state_q <= ARB_IDLE;
          end
        end

        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_write_req  = mem_write_req_q;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read_req   = mem_read_req_q;
  assign mem_read_addr  = mem_read_addr_q;

  assign i_write_ack    = i_write_ack_q;
  assign i_read_ack     = i_read_ack_q;
  assign d_write_ack    = d_write_ack_q;
  assign d_read_ack     = d_read_ack_q;
  assign i_read_data    = i_read_data_q;
  assign d_read_data    = d_read_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_write_req, i_read_req, d_write_req, d_read_req;
  logic [31:0] i_write_addr, i_write_data, i_read_addr;
  logic [31:0] d_write_addr, d_write_data, d_read_addr;
  logic        i_write_ack, i_read_ack, d_write_ack, d_read_ack;
  logic [31:0] i_read_data, d_read_data;
  logic        mem_write_req, mem_read_req;
  logic [31:0] mem_write_addr, mem_write_data, mem_read_addr;
  logic        mem_write_ack, mem_read_ack;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_write_req(i_write_req), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .i_write_ack(i_write_ack), .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .i_read_data(i_read_data), .i_read_ack(i_read_ack),
    .d_write_req(d_write_req), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
    .d_write_ack(d_write_ack), .d_read_req(d_read_req), .d_read_addr(d_read_addr),
    .d_read_data(d_read_data), .d_read_ack(d_read_ack),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ack(mem_write_ack),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Downstream transaction record; clients are told apart by addr[31]
  // (icache addresses have it clear, dcache addresses set).
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chain;
  } op_t;

  op_t mem_log[$];
  op_t i_exp[$];
  op_t d_exp[$];

  // Memory model: read data is a fixed function of the address.
  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  bit          mem_auto = 1'b0;
  bit          mm_busy = 1'b0;
  int          mm_cnt = 0;
  bit          mm_wr = 1'b0;
  logic [31:0] mm_addr = '0;

  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_write_ack = 1'b0;
        mem_read_ack  = 1'b0;
        if (!mm_busy && (mem_write_req || mem_read_req)) begin
          mm_busy = 1'b1;
          mm_cnt  = $urandom_range(0, 3);
          mm_wr   = mem_write_req;
          mm_addr = mem_write_req ? mem_write_addr : mem_read_addr;
          mem_log.push_back('{mm_wr, mm_addr, mm_wr ? mem_write_data : 32'h0, 1'b0});
        end
        if (mm_busy) begin
          if (mm_cnt == 0) begin
            mm_busy = 1'b0;
            if (mm_wr) mem_write_ack = 1'b1;
            else begin
              mem_read_ack  = 1'b1;
              mem_read_data = hash(mm_addr);
            end
          end else begin
            mm_cnt--;
          end
        end
      end else begin
        mm_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_clients();
    i_write_req = 0; i_read_req = 0; d_write_req = 0; d_read_req = 0;
    i_write_addr = 0; i_write_data = 0; i_read_addr = 0;
    d_write_addr = 0; d_write_data = 0; d_read_addr = 0;
  endtask

  task automatic do_reset();
    mem_auto = 1'b0;
    mem_write_ack = 0; mem_read_ack = 0; mem_read_data = 0;
    clear_clients();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mem_write_ack = 0; mem_read_ack = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_write_ack = 0; mem_read_ack = 0; mem_read_data = 0;
    clear_clients();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mem_write_req, mem_read_req} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_mem_req: got %b expected 00", {mem_write_req, mem_read_req});
    end
    tests_run++;
    if ({mem_write_addr, mem_read_addr, mem_write_data} !== 96'h0) begin
      tests_failed++; $display("FAIL reset_mem_addr_data: got %h expected 0", {mem_write_addr, mem_read_addr, mem_write_data});
    end
    tests_run++;
    if ({i_write_ack, i_read_ack, d_write_ack, d_read_ack} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_acks: got %b expected 0000", {i_write_ack, i_read_ack, d_write_ack, d_read_ack});
    end
    tests_run++;
    if ({i_read_data, d_read_data} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_read_data: got %h expected 0", {i_read_data, d_read_data});
    end
    // A request while reset is held must not reach memory.
    i_read_req = 1; i_read_addr = 32'h0000_0100;
    @(negedge clk);
    tests_run++;
    if (mem_read_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_holds_req: got %b expected 0", mem_read_req);
    end
    clear_clients();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lone_dread();
    do_reset();
    d_read_req = 1; d_read_addr = 32'h0000_1040;
    tests_run++;
    if (mem_read_req !== 1'b0) begin
      tests_failed++; $display("FAIL lone_req_early: got %b expected 0", mem_read_req);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_read_req, mem_write_req, mem_read_addr} !== {2'b10, 32'h0000_1040}) begin
      tests_failed++; $display("FAIL lone_req_latency: got %b%b %h expected 10 00001040", mem_read_req, mem_write_req, mem_read_addr);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mem_read_req, d_read_ack} !== 2'b10) begin
      tests_failed++; $display("FAIL lone_wait: got %b expected 10", {mem_read_req, d_read_ack});
    end
    mem_read_ack = 1; mem_read_data = 32'hDEADBEEF;
    @(negedge clk);
    mem_read_ack = 0; mem_read_data = 0;
    tests_run++;
    if ({d_read_ack, i_read_ack, d_read_data} !== {2'b10, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL lone_ack: got %b%b %h expected 10 deadbeef", d_read_ack, i_read_ack, d_read_data);
    end
    d_read_req = 0;
    @(negedge clk);
    tests_run++;
    if ({d_read_ack, mem_read_req, d_read_data} !== {2'b00, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL lone_pulse_end: got %b%b %h expected 00 deadbeef", d_read_ack, mem_read_req, d_read_data);
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    i_read_req = 1; i_read_addr = 32'h0000_5000;
    @(negedge clk);
    mem_write_ack = 1;
    @(negedge clk);
    mem_write_ack = 0;
    tests_run++;
    if ({mem_read_req, i_write_ack, i_read_ack} !== 3'b100) begin
      tests_failed++; $display("FAIL spurious_ignored: got %b expected 100", {mem_read_req, i_write_ack, i_read_ack});
    end
    @(negedge clk);
    tests_run++;
    if (mem_read_req !== 1'b1) begin
      tests_failed++; $display("FAIL spurious_stay_read: got %b expected 1", mem_read_req);
    end
    mem_read_ack = 1; mem_read_data = 32'hCAFEF00D;
    @(negedge clk);
    mem_read_ack = 0;
    tests_run++;
    if ({i_read_ack, i_write_ack, i_read_data} !== {2'b10, 32'hCAFEF00D}) begin
      tests_failed++; $display("FAIL spurious_read_done: got %b%b %h expected 10 cafef00d", i_read_ack, i_write_ack, i_read_data);
    end
    i_read_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    d_read_req = 1; d_read_addr = 32'h8000_7000;
    @(negedge clk);
    tests_run++;
    if (mem_read_req !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_in_read: got %b expected 1", mem_read_req);
    end
    reset = 0;
    @(negedge clk);
    tests_run++;
    if ({mem_read_req, i_write_ack, i_read_ack, d_write_ack, d_read_ack} !== 5'b0) begin
      tests_failed++; $display("FAIL midrst_abandon: got %b expected 00000", {mem_read_req, i_write_ack, i_read_ack, d_write_ack, d_read_ack});
    end
    reset = 1; d_read_req = 0;
    @(negedge clk);
    mem_read_ack = 1; mem_read_data = 32'h0BAD0BAD;
    @(negedge clk);
    mem_read_ack = 0;
    tests_run++;
    if ({i_read_ack, d_read_ack, d_read_data} !== {2'b00, 32'h0}) begin
      tests_failed++; $display("FAIL midrst_stale_ack: got %b%b %h expected 00 0", i_read_ack, d_read_ack, d_read_data);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_read_req, mem_write_req, d_read_ack} !== 3'b000) begin
      tests_failed++; $display("FAIL midrst_idle: got %b expected 000", {mem_read_req, mem_write_req, d_read_ack});
    end
  endtask

  task automatic test_evict_fill();
    bit d_started = 0, iw = 0, ir = 0, dr = 0;
    int t = 0;
    do_reset();
    mem_log.delete();
    mem_auto = 1;
    i_write_req = 1; i_write_addr = 32'h0000_2000; i_write_data = 32'h0000_1111;
    i_read_req = 1;  i_read_addr = 32'h0000_3000;
    while (!(iw && ir && dr) && t < 300) begin
      @(negedge clk); t++;
      if (i_write_ack) begin i_write_req = 0; iw = 1; end
      if (i_read_ack) begin
        tests_run++;
        if ({iw, i_read_data} !== {1'b1, hash(32'h0000_3000)}) begin
          tests_failed++; $display("FAIL ef_fill_data: got %b %h expected 1 %h", iw, i_read_data, hash(32'h0000_3000));
        end
        i_read_req = 0; ir = 1;
      end
      if (d_read_ack) begin d_read_req = 0; dr = 1; end
      if (mem_write_req && !d_started) begin
        d_read_req = 1; d_read_addr = 32'h8000_1000; d_started = 1;
      end
    end
    tests_run++;
    if (!(iw && ir && dr)) begin
      tests_failed++; $display("FAIL ef_timeout: got %b%b%b expected 111", iw, ir, dr);
      clear_clients();
    end
    tests_run++;
    if (mem_log.size() != 3) begin
      tests_failed++; $display("FAIL ef_count: got %0d expected 3", mem_log.size());
    end else begin
      tests_run++;
      if ({mem_log[0].wr, mem_log[0].addr, mem_log[0].data} !== {1'b1, 32'h0000_2000, 32'h0000_1111}) begin
        tests_failed++; $display("FAIL ef_first_write: got %b %h %h expected 1 00002000 00001111", mem_log[0].wr, mem_log[0].addr, mem_log[0].data);
      end
      tests_run++;
      if ({mem_log[1].wr, mem_log[1].addr} !== {1'b0, 32'h0000_3000}) begin
        tests_failed++; $display("FAIL ef_chained_read: got %b %h expected 0 00003000", mem_log[1].wr, mem_log[1].addr);
      end
      tests_run++;
      if ({mem_log[2].wr, mem_log[2].addr} !== {1'b0, 32'h8000_1000}) begin
        tests_failed++; $display("FAIL ef_dcache_after: got %b %h expected 0 80001000", mem_log[2].wr, mem_log[2].addr);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    do_reset();
    mem_log.delete();
    mem_auto = 1;
    for (int p = 0; p < 4; p++) begin
      bit idn = 0, ddn = 0;
      int t = 0;
      i_read_req = 1; i_read_addr = 32'h0000_A000 + 32'(p * 16);
      d_read_req = 1; d_read_addr = 32'h8000_A000 + 32'(p * 16);
      while (!(idn && ddn) && t < 200) begin
        @(negedge clk); t++;
        if (i_read_ack) begin
          tests_run++;
          if ({d_read_ack, i_read_data} !== {1'b0, hash(i_read_addr)}) begin
            tests_failed++; $display("FAIL cont_i_data: got %b %h expected 0 %h", d_read_ack, i_read_data, hash(i_read_addr));
          end
          i_read_req = 0; idn = 1;
        end
        if (d_read_ack) begin
          tests_run++;
          if (d_read_data !== hash(d_read_addr)) begin
            tests_failed++; $display("FAIL cont_d_data: got %h expected %h", d_read_data, hash(d_read_addr));
          end
          d_read_req = 0; ddn = 1;
        end
      end
      tests_run++;
      if (!(idn && ddn)) begin
        tests_failed++; $display("FAIL cont_timeout: pair %0d got %b%b expected 11", p, idn, ddn);
        clear_clients();
      end
    end
    tests_run++;
    if (mem_log.size() != 8) begin
      tests_failed++; $display("FAIL cont_count: got %0d expected 8", mem_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (mem_log[k].addr[31] !== ((k % 2) == 0)) begin
          tests_failed++; $display("FAIL cont_order: slot %0d got dcache=%b expected dcache=%b", k, mem_log[k].addr[31], (k % 2) == 0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int d_acks = 0, i_acks = 0, t = 0;
    bit i_done = 0;
    do_reset();
    mem_auto = 1;
    d_read_req = 1; d_read_addr = 32'h8000_B000;
    @(negedge clk);
    i_read_req = 1; i_read_addr = 32'h0000_B000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    while (!i_done && t < 300) begin
      @(negedge clk); t++;
      if (d_read_ack) d_acks++;
      if (i_read_ack) begin
        tests_run++;
        if (i_read_data !== hash(32'h0000_B000)) begin
          tests_failed++; $display("FAIL starve_data: got %h expected %h", i_read_data, hash(32'h0000_B000));
        end
        i_read_req = 0; i_done = 1;
      end
    end
    tests_run++;
    if (!i_done || d_acks > 2) begin
      tests_failed++; $display("FAIL starve_bound: served=%b dcache_before=%0d expected served within 2", i_done, d_acks);
    end
`else
    while (d_acks < 3 && t < 300) begin
      @(negedge clk); t++;
      if (d_read_ack) d_acks++;
      if (i_read_ack) i_acks++;
    end
    tests_run++;
    if (d_acks != 3 || i_acks != 0) begin
      tests_failed++; $display("FAIL prio_dcache_hog: got d=%0d i=%0d expected d=3 i=0", d_acks, i_acks);
    end
    d_read_req = 0;
    t = 0;
    while (!i_done && t < 100) begin
      @(negedge clk); t++;
      if (i_read_ack) begin i_read_req = 0; i_done = 1; end
    end
    tests_run++;
    if (!i_done) begin
      tests_failed++; $display("FAIL prio_icache_after: got served=0 expected 1");
    end
`endif
    clear_clients();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_client(input bit is_d, input int n);
    for (int k = 0; k < n; k++) begin
      int kind, t;
      logic [31:0] wa, ra, wd, rd;
      bit need_w, need_r, got_w, got_r, wa_s, ra_s, wq, rq, oth;
      kind = $urandom_range(0, 2);
      wa = {is_d, 27'($urandom), 4'h0};
      ra = {is_d, 27'($urandom), 4'h0};
      wd = $urandom;
      need_w = (kind != 1); need_r = (kind != 0);
      got_w = 0; got_r = 0; t = 0;
      if (is_d) begin
        if (need_w) d_exp.push_back('{1'b1, wa, wd, need_r});
        if (need_r) d_exp.push_back('{1'b0, ra, 32'h0, 1'b0});
        d_write_addr = wa; d_write_data = wd; d_read_addr = ra;
        d_write_req = need_w; d_read_req = need_r;
      end else begin
        if (need_w) i_exp.push_back('{1'b1, wa, wd, need_r});
        if (need_r) i_exp.push_back('{1'b0, ra, 32'h0, 1'b0});
        i_write_addr = wa; i_write_data = wd; i_read_addr = ra;
        i_write_req = need_w; i_read_req = need_r;
      end
      while (((need_w && !got_w) || (need_r && !got_r)) && t < 2000) begin
        @(negedge clk); t++;
        wa_s = is_d ? d_write_ack : i_write_ack;
        ra_s = is_d ? d_read_ack  : i_read_ack;
        rd   = is_d ? d_read_data : i_read_data;
        wq   = is_d ? d_write_req : i_write_req;
        rq   = is_d ? d_read_req  : i_read_req;
        oth  = is_d ? (i_write_ack | i_read_ack) : (d_write_ack | d_read_ack);
        if (wa_s) begin
          tests_run++;
          if (!wq || oth || ra_s) begin
            tests_failed++; $display("FAIL rand_wack: client %0d got req=%b other=%b rack=%b expected 1 0 0", is_d, wq, oth, ra_s);
          end
          got_w = 1;
          if (is_d) d_write_req = 0; else i_write_req = 0;
        end
        if (ra_s) begin
          tests_run++;
          if (!rq || oth || rd !== hash(ra)) begin
            tests_failed++; $display("FAIL rand_rack: client %0d got req=%b other=%b data=%h expected 1 0 %h", is_d, rq, oth, rd, hash(ra));
          end
          got_r = 1;
          if (is_d) d_read_req = 0; else i_read_req = 0;
        end
      end
      if ((need_w && !got_w) || (need_r && !got_r)) begin
        tests_run++; tests_failed++;
        $display("FAIL rand_timeout: client %0d txn %0d got w=%b r=%b", is_d, k, got_w, got_r);
        if (is_d) begin d_write_req = 0; d_read_req = 0; end
        else begin i_write_req = 0; i_read_req = 0; end
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int chain_cli = -1;
    do_reset();
    mem_log.delete(); i_exp.delete(); d_exp.delete();
    mem_auto = 1;
    fork
      run_client(1'b0, 25);
      run_client(1'b1, 25);
    join
    repeat (4) @(negedge clk);
    foreach (mem_log[k]) begin
      op_t e, h;
      bit from_d;
      e = mem_log[k];
      from_d = e.addr[31];
      if (chain_cli >= 0) begin
        tests_run++;
        if (e.wr || (from_d != (chain_cli == 1))) begin
          tests_failed++; $display("FAIL rand_chain: slot %0d got wr=%b dcache=%b expected read from client %0d", k, e.wr, from_d, chain_cli);
        end
        chain_cli = -1;
      end
      tests_run++;
      if (from_d ? (d_exp.size() == 0) : (i_exp.size() == 0)) begin
        tests_failed++; $display("FAIL rand_unexpected: slot %0d got addr %h expected none", k, e.addr);
        continue;
      end
      if (from_d) h = d_exp.pop_front(); else h = i_exp.pop_front();
      if (h.wr !== e.wr || h.addr !== e.addr || (e.wr && h.data !== e.data)) begin
        tests_failed++; $display("FAIL rand_order: slot %0d got %b %h %h expected %b %h %h", k, e.wr, e.addr, e.data, h.wr, h.addr, h.data);
      end
      if (h.chain) chain_cli = from_d ? 1 : 0;
    end
    tests_run++;
    if (i_exp.size() != 0 || d_exp.size() != 0) begin
      tests_failed++; $display("FAIL rand_leftover: got i=%0d d=%0d expected 0 0", i_exp.size(), d_exp.size());
    end
    mem_auto = 0;
  endtask

  initial begin
    reset = 1'b0;
    mem_write_ack = 0; mem_read_ack = 0; mem_read_data = 0;
    clear_clients();
    test_reset();
    test_lone_dread();
    test_spurious_ack();
    test_reset_mid_read();
    test_evict_fill();
    test_contention();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
